// File: rtl/k6502_int_ctrl.sv
// k6502_int_ctrl: interrupt controller (RST > NMI > IRQ); optional service counters via K6502_INT_STATS_EN
module k6502_int_ctrl #(
    parameter int N_IRQ       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int SRC_W       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef K6502_INT_STATS_EN
    input  logic             cnt_clr,
    output logic [15:0]      cnt_nmi,
    output logic [15:0]      cnt_irq,
`endif
    input  logic             sync,
    input  logic             i_flag,
    input  logic             int_ack,
    input  logic             nmi_n,
    input  logic [N_IRQ-1:0] irq_n,
    input  logic [N_IRQ-1:0] irq_en,
    output logic             rst,
    output logic             nmi,
    output logic             irq,
    output logic [7:0]       vec_lo,
    output logic [SRC_W-1:0] irq_src,
    output logic             nmi_pending
);
    typedef enum logic [1:0] {IDLE, SVC_RST, SVC_NMI, SVC_IRQ} state_t;
    state_t           r_state, w_next;
    logic [SYNC_STAGES-1:0] r_nmi_sync;
    logic [N_IRQ-1:0] r_irq_sync [SYNC_STAGES];
    logic             r_nmi_prev, r_nmi_pend, r_rst_pend;
    logic [SRC_W-1:0] r_irq_src, w_src;
    logic [N_IRQ-1:0] w_irq_act;
    logic             w_nmi_edge, w_irq_req, w_take_rst, w_take_nmi, w_take_irq;
    assign w_nmi_edge  = r_nmi_prev & ~r_nmi_sync[SYNC_STAGES-1];
    assign w_irq_act   = ~r_irq_sync[SYNC_STAGES-1] & irq_en;
    assign w_irq_req   = |w_irq_act & ~i_flag;
    assign rst         = r_state == SVC_RST;
    assign nmi         = r_state == SVC_NMI;
    assign irq         = r_state == SVC_IRQ;
    assign vec_lo      = rst ? 8'hFC : nmi ? 8'hFA : 8'hFE;
    assign irq_src     = r_irq_src;
    assign nmi_pending = r_nmi_pend;
    // pin synchronisers; idle level is 1 so reset cannot fake an NMI edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_nmi_sync <= '1;
            r_nmi_prev <= 1'b1;
            for (int k = 0; k < SYNC_STAGES; k++) r_irq_sync[k] <= '1;
        end else begin
            r_nmi_sync[0] <= nmi_n;
            r_irq_sync[0] <= irq_n;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_nmi_sync[k] <= r_nmi_sync[k-1];
                r_irq_sync[k] <= r_irq_sync[k-1];
            end
            r_nmi_prev <= r_nmi_sync[SYNC_STAGES-1];
        end
    end
    // lowest-numbered enabled and asserted IRQ source
    always_comb begin
        w_src = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) if (w_irq_act[i]) w_src = SRC_W'(i);
    end
    // priority take at instruction boundary; services end only on ack
    always_comb begin
        w_next     = r_state;
        w_take_rst = 1'b0;
        w_take_nmi = 1'b0;
        w_take_irq = 1'b0;
        if (r_state == IDLE) begin
            w_take_rst = sync & r_rst_pend;
            w_take_nmi = sync & ~r_rst_pend & r_nmi_pend;
            w_take_irq = sync & ~r_rst_pend & ~r_nmi_pend & w_irq_req;
            w_next     = w_take_rst ? SVC_RST : w_take_nmi ? SVC_NMI : w_take_irq ? SVC_IRQ : IDLE;
        end else if (int_ack) begin
            w_next = IDLE;
        end
    end
    // state, pending flags and latched source; a fresh NMI edge beats the clear on take
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rst_pend <= 1'b1;
            r_nmi_pend <= 1'b0;
            r_irq_src  <= '0;
        end else begin
            r_state    <= w_next;
            r_rst_pend <= r_rst_pend & ~w_take_rst;
            r_nmi_pend <= w_nmi_edge | (r_nmi_pend & ~w_take_nmi);
            if (w_take_irq) r_irq_src <= w_src;
        end
    end
`ifdef K6502_INT_STATS_EN
    logic [15:0] r_cnt_nmi, r_cnt_irq;
    assign cnt_nmi = r_cnt_nmi;
    assign cnt_irq = r_cnt_irq;
    // saturating service counters; clear dominates increment
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            r_cnt_nmi <= '0;
            r_cnt_irq <= '0;
        end else begin
            if (w_take_nmi && r_cnt_nmi != 16'hFFFF) r_cnt_nmi <= r_cnt_nmi + 16'd1;
            if (w_take_irq && r_cnt_irq != 16'hFFFF) r_cnt_irq <= r_cnt_irq + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_k6502_int_ctrl.sv
// tb_k6502_int_ctrl: directed and random checks of k6502_int_ctrl against a service-level model
module tb_k6502_int_ctrl;
    localparam int N = 4, S = 2, W = 3;
    logic         clk = 1'b0, rst_n = 1'b0, sync = 1'b0, i_flag = 1'b0, int_ack = 1'b0, nmi_n = 1'b1;
    logic [N-1:0] irq_n = '1, irq_en = '1;
    logic         rst, nmi, irq, nmi_pending;
    logic [7:0]   vec_lo;
    logic [W-1:0] irq_src;
    int           checks = 0, failures = 0;
    int           m_svc;
    logic         m_rst_pend, m_nmi_pend;
    logic [W-1:0] m_src;
    logic         m_nmi_h [S+1];
    logic [N-1:0] m_irq_h [S+1];
`ifdef K6502_INT_STATS_EN
    logic         cnt_clr = 1'b0;
    logic [15:0]  cnt_nmi, cnt_irq, m_cn, m_ci;
`endif

    k6502_int_ctrl #(.N_IRQ(N), .SYNC_STAGES(S), .SRC_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef K6502_INT_STATS_EN
        .cnt_clr(cnt_clr), .cnt_nmi(cnt_nmi), .cnt_irq(cnt_irq),
`endif
        .sync(sync), .i_flag(i_flag), .int_ack(int_ack), .nmi_n(nmi_n),
        .irq_n(irq_n), .irq_en(irq_en), .rst(rst), .nmi(nmi), .irq(irq),
        .vec_lo(vec_lo), .irq_src(irq_src), .nmi_pending(nmi_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // service-level model: m_*_h[0] is the newest pin sample, [S-1] the synced view, [S] its previous value
    task automatic model_edge();
        logic         fall;
        logic [N-1:0] act;
        logic         req, in_nmi, in_irq;
        in_nmi = 1'b0;
        in_irq = 1'b0;
        if (!rst_n) begin
            m_svc = 0; m_src = '0; m_nmi_pend = 1'b0; m_rst_pend = 1'b1;
            for (int i = 0; i <= S; i++) begin m_nmi_h[i] = 1'b1; m_irq_h[i] = '1; end
`ifdef K6502_INT_STATS_EN
            m_cn = '0; m_ci = '0;
`endif
        end else begin
            fall = m_nmi_h[S] & ~m_nmi_h[S-1];
            act  = ~m_irq_h[S-1] & irq_en;
            req  = (act != '0) && !i_flag;
            if (m_svc == 0 && sync) begin
                if (m_rst_pend) begin m_svc = 1; m_rst_pend = 1'b0; end
                else if (m_nmi_pend) begin m_svc = 2; m_nmi_pend = 1'b0; in_nmi = 1'b1; end
                else if (req) begin
                    m_svc = 3; in_irq = 1'b1;
                    for (int i = 0; i < N; i++) if (act[i]) begin m_src = W'(i); break; end
                end
            end else if (m_svc != 0 && int_ack) m_svc = 0;
            if (fall) m_nmi_pend = 1'b1;
            for (int i = S; i > 0; i--) begin m_nmi_h[i] = m_nmi_h[i-1]; m_irq_h[i] = m_irq_h[i-1]; end
            m_nmi_h[0] = nmi_n;
            m_irq_h[0] = irq_n;
`ifdef K6502_INT_STATS_EN
            if (cnt_clr) begin m_cn = '0; m_ci = '0; end
            else begin
                if (in_nmi && m_cn < 16'hFFFF) m_cn++;
                if (in_irq && m_ci < 16'hFFFF) m_ci++;
            end
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("rst", 32'(rst), 32'(m_svc == 1));
        chk("nmi", 32'(nmi), 32'(m_svc == 2));
        chk("irq", 32'(irq), 32'(m_svc == 3));
        chk("vec_lo", 32'(vec_lo), m_svc == 1 ? 32'hFC : m_svc == 2 ? 32'hFA : 32'hFE);
        chk("irq_src", 32'(irq_src), 32'(m_src));
        chk("nmi_pending", 32'(nmi_pending), 32'(m_nmi_pend));
`ifdef K6502_INT_STATS_EN
        chk("cnt_nmi", 32'(cnt_nmi), 32'(m_cn));
        chk("cnt_irq", 32'(cnt_irq), 32'(m_ci));
`endif
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_n = 1'b0;
        steps(2);
        chk("reset_vec", 32'(vec_lo), 32'hFE);
        chk("reset_pend", 32'(nmi_pending), 32'h0);
        rst_n = 1'b1;
        steps(2);
        sync = 1'b1; step(); sync = 1'b0;
        chk("t1_rst", 32'(rst), 32'h1);
        chk("t1_vec", 32'(vec_lo), 32'hFC);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        chk("t1_ack_vec", 32'(vec_lo), 32'hFE);
        nmi_n = 1'b0;
        steps(2);
        chk("t2_lat2", 32'(nmi_pending), 32'h0);
        step();
        chk("t2_lat3", 32'(nmi_pending), 32'h1);
        sync = 1'b1; step(); sync = 1'b0;
        chk("t2_nmi", 32'(nmi), 32'h1);
        chk("t2_vec", 32'(vec_lo), 32'hFA);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        sync = 1'b1; step(); sync = 1'b0;
        chk("t2_no_second", 32'(nmi), 32'h0);
        irq_n = 4'b0101; irq_en = 4'b1110; i_flag = 1'b1;
        steps(3);
        sync = 1'b1; step(); sync = 1'b0;
        chk("t3_masked", 32'(irq), 32'h0);
        i_flag = 1'b0;
        sync = 1'b1; step(); sync = 1'b0;
        chk("t3_irq", 32'(irq), 32'h1);
        chk("t3_src", 32'(irq_src), 32'h1);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        nmi_n = 1'b1; steps(3);
        nmi_n = 1'b0; steps(3);
        sync = 1'b1; step(); sync = 1'b0;
        chk("t4_nmi_first", 32'(nmi), 32'h1);
        int_ack = 1'b1; step(); int_ack = 1'b0;
        sync = 1'b1; step(); sync = 1'b0;
        chk("t4_irq_next", 32'(irq), 32'h1);
        nmi_n = 1'b1; steps(3);
        irq_n = '1;
        nmi_n = 1'b0; steps(3);
        chk("t5_pend_in_svc", 32'(nmi_pending), 32'h1);
        chk("t5_src_stable", 32'(irq_src), 32'h1);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("t5_rst_irq", 32'(irq), 32'h0);
        chk("t5_rst_pend", 32'(nmi_pending), 32'h0);
        sync = 1'b1; step();
        chk("t5_rst_svc", 32'(rst), 32'h1);
        int_ack = 1'b1; step(); int_ack = 1'b0; sync = 1'b0;
        chk("ack_wins", 32'(rst), 32'h0);
        for (int c = 0; c < 3000; c++) begin
            sync    = ($urandom_range(99) < 30);
            int_ack = ($urandom_range(99) < 30);
            i_flag  = ($urandom_range(99) < 25);
            rst_n   = ($urandom_range(99) >= 2);
            if ($urandom_range(99) < 10) nmi_n = ~nmi_n;
            if ($urandom_range(99) < 15) irq_n = N'($urandom);
            if ($urandom_range(99) < 5) irq_en = N'($urandom);
`ifdef K6502_INT_STATS_EN
            cnt_clr = ($urandom_range(99) < 2);
`endif
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
